// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encodings and
// last-served pointer values used by both the register core and the picker.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_GNT0 = 2'd1,
        ARB_GNT1 = 2'd2
    } arb_state_e;

    localparam logic LAST_P0 = 1'b0;
    localparam logic LAST_P1 = 1'b1;

    function automatic logic is_gnt(input arb_state_e s);
        return (s == ARB_GNT0) || (s == ARB_GNT1);
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational next-owner selection: lock hold with burst limit, then
// round-robin on contention, then single requester, else idle.
module arb_rr_pick
    import mem_arbiter_pkg::*;
(
    input  arb_state_e state_i,
    input  logic       req0_i,
    input  logic       req1_i,
    input  logic       lock0_i,
    input  logic       lock1_i,
    input  logic       last_i,
    input  logic       burst_max_i,
    output arb_state_e next_o
);

    logic hold0;
    logic hold1;

    // A locked owner keeps the grant unless the other port is waiting and the burst is spent.
    assign hold0 = (state_i == ARB_GNT0) && req0_i && lock0_i && (!req1_i || !burst_max_i);
    assign hold1 = (state_i == ARB_GNT1) && req1_i && lock1_i && (!req0_i || !burst_max_i);

    always_comb begin
        next_o = ARB_IDLE;
        if (hold0) begin
            next_o = ARB_GNT0;
        end else if (hold1) begin
            next_o = ARB_GNT1;
        end else if (req0_i && req1_i) begin
            next_o = (last_i == LAST_P0) ? ARB_GNT1 : ARB_GNT0;
        end else if (req0_i) begin
            next_o = ARB_GNT0;
        end else if (req1_i) begin
            next_o = ARB_GNT1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory with
// lockable bursts and registered per-port read results.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ARB_IDLE | no grant; memory outputs driven to zero
//   ARB_GNT0 | port 0 owns the memory, its transaction runs
//   ARB_GNT1 | port 1 owns the memory, its transaction runs
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int p_WORD_LEN  = 16,
    parameter int p_ADDR_LEN  = 10,
    parameter int p_MAX_BURST = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,

    input  logic                  i_p0_req,
    input  logic                  i_p0_we,
    input  logic                  i_p0_lock,
    input  logic [p_ADDR_LEN-1:0] i_p0_addr,
    input  logic [p_WORD_LEN-1:0] i_p0_wr_data,
    output logic                  o_p0_ack,
    output logic [p_WORD_LEN-1:0] o_p0_rd_data,
    output logic                  o_p0_rd_valid,

    input  logic                  i_p1_req,
    input  logic                  i_p1_we,
    input  logic                  i_p1_lock,
    input  logic [p_ADDR_LEN-1:0] i_p1_addr,
    input  logic [p_WORD_LEN-1:0] i_p1_wr_data,
    output logic                  o_p1_ack,
    output logic [p_WORD_LEN-1:0] o_p1_rd_data,
    output logic                  o_p1_rd_valid,

    output logic                  o_mem_wr_en,
    output logic [p_ADDR_LEN-1:0] o_mem_addr,
    output logic [p_WORD_LEN-1:0] o_mem_wr_data,
    input  logic [p_WORD_LEN-1:0] i_mem_rd_data
);

    localparam int                BURST_W   = (p_MAX_BURST > 2) ? $clog2(p_MAX_BURST) : 1;
    localparam logic [BURST_W-1:0] BURST_SAT = BURST_W'(p_MAX_BURST - 1);

    arb_state_e         state_q;
    arb_state_e         state_d;
    arb_state_e         pick_next;
    logic               last_q;
    logic               last_d;
    logic [BURST_W-1:0] burst_q;
    logic [BURST_W-1:0] burst_d;
    logic               burst_max;

    logic                  rd_fire0;
    logic                  rd_fire1;
    logic [p_WORD_LEN-1:0] rd_data0_q;
    logic [p_WORD_LEN-1:0] rd_data0_d;
    logic [p_WORD_LEN-1:0] rd_data1_q;
    logic [p_WORD_LEN-1:0] rd_data1_d;
    logic                  rd_valid0_q;
    logic                  rd_valid1_q;

    logic                  mem_wr_en;
    logic [p_ADDR_LEN-1:0] mem_addr;
    logic [p_WORD_LEN-1:0] mem_wr_data;

    arb_rr_pick u_pick (
        .state_i     (state_q),
        .req0_i      (i_p0_req),
        .req1_i      (i_p1_req),
        .lock0_i     (i_p0_lock),
        .lock1_i     (i_p1_lock),
        .last_i      (last_q),
        .burst_max_i (burst_max),
        .next_o      (pick_next)
    );

    always_comb begin
        burst_max = (burst_q == BURST_SAT);
        state_d   = pick_next;

        last_d = last_q;
        if (state_d == ARB_GNT0) begin
            last_d = LAST_P0;
        end else if (state_d == ARB_GNT1) begin
            last_d = LAST_P1;
        end

        // Counts repeat grants to the same owner; any switch or idle restarts it.
        burst_d = '0;
        if (is_gnt(state_q) && (state_d == state_q)) begin
            burst_d = burst_max ? burst_q : burst_q + BURST_W'(1);
        end
    end

    always_comb begin
        rd_fire0   = (state_q == ARB_GNT0) && i_p0_req && !i_p0_we;
        rd_fire1   = (state_q == ARB_GNT1) && i_p1_req && !i_p1_we;
        rd_data0_d = rd_fire0 ? i_mem_rd_data : rd_data0_q;
        rd_data1_d = rd_fire1 ? i_mem_rd_data : rd_data1_q;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= ARB_IDLE;
            last_q      <= LAST_P1;
            burst_q     <= '0;
            rd_data0_q  <= '0;
            rd_data1_q  <= '0;
            rd_valid0_q <= 1'b0;
            rd_valid1_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            burst_q     <= burst_d;
            rd_data0_q  <= rd_data0_d;
            rd_data1_q  <= rd_data1_d;
            rd_valid0_q <= rd_fire0;
            rd_valid1_q <= rd_fire1;
        end
    end

    always_comb begin
        mem_wr_en   = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        case (state_q)
            ARB_GNT0: begin
                mem_wr_en   = i_p0_req && i_p0_we;
                mem_addr    = i_p0_addr;
                mem_wr_data = i_p0_wr_data;
            end
            ARB_GNT1: begin
                mem_wr_en   = i_p1_req && i_p1_we;
                mem_addr    = i_p1_addr;
                mem_wr_data = i_p1_wr_data;
            end
            default: ;
        endcase
    end

    // Reset gates the write strobe combinationally so a grant cut short by reset never commits.
    assign o_mem_wr_en   = mem_wr_en && i_rst_n;
    assign o_mem_addr    = mem_addr;
    assign o_mem_wr_data = mem_wr_data;

    assign o_p0_ack      = (state_q == ARB_GNT0);
    assign o_p1_ack      = (state_q == ARB_GNT1);
    assign o_p0_rd_data  = rd_data0_q;
    assign o_p1_rd_data  = rd_data1_q;
    assign o_p0_rd_valid = rd_valid0_q;
    assign o_p1_rd_valid = rd_valid1_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: p_WORD_LEN, default 16, word width; p_ADDR_LEN, default 10, address width; p_MAX_BURST, default 4, maximum consecutive locked grants while the other port waits (minimum 2).
REQ-002 i_clk  in  1  clock; all state changes on posedge.
REQ-003 i_rst_n  in  1  reset; synchronous, active-low.
REQ-004 i_pN_req  in  1  (N=0,1) port N transaction request; held until acked.
REQ-005 i_pN_we  in  1  port N write (1) / read (0).
REQ-006 i_pN_lock  in  1  port N requests to keep its grant for the next transaction.
REQ-007 i_pN_addr  in  p_ADDR_LEN  port N word address.
REQ-008 i_pN_wr_data  in  p_WORD_LEN  port N write data.
REQ-009 o_pN_ack  out  1  port N is granted this cycle; its transaction executes this cycle.
REQ-010 o_pN_rd_data  out  p_WORD_LEN  port N last read result (registered).
REQ-011 o_pN_rd_valid  out  1  one-cycle pulse: o_pN_rd_data was updated at the previous posedge.
REQ-012 o_mem_wr_en  out  1  to data memory write enable (memory writes on negedge).
REQ-013 o_mem_addr  out  p_ADDR_LEN  to data memory address.
REQ-014 o_mem_wr_data  out  p_WORD_LEN  to data memory write data.
REQ-015 i_mem_rd_data  in  p_WORD_LEN  asynchronous read data from data memory.

Function
REQ-016 FSM states SHALL be IDLE, GNT0, GNT1; o_pN_ack SHALL equal (state==GNTN), decoded from the state register only.
REQ-017 Latency: a request first sampled at posedge k SHALL be acked at the earliest in the cycle after posedge k (1-cycle grant latency).
REQ-018 Next state SHALL be: stay GNTN if i_pN_req && i_pN_lock && (other port idle || burst count < p_MAX_BURST-1); else if both request -> grant the port not last served; else if one requests -> grant it; else IDLE.
REQ-019 Without lock, back-to-back grants to the same port SHALL occur only when the other port is not requesting.
REQ-020 Burst counter SHALL increment on each consecutive grant to the same port, saturate at p_MAX_BURST-1, and clear on port switch or IDLE.
REQ-021 Last-served pointer SHALL update to N whenever GNTN is entered.
REQ-022 Memory outputs SHALL be a combinational mux of the granted port; in IDLE all memory outputs SHALL be 0.
REQ-023 o_mem_wr_en SHALL be i_pN_we && i_pN_req in GNTN, and SHALL be forced 0 whenever i_rst_n is low.
REQ-024 On a posedge ending a GNTN cycle with i_pN_req=1 and i_pN_we=0, o_pN_rd_data SHALL capture i_mem_rd_data and o_pN_rd_valid SHALL be 1 for the following cycle only.
REQ-025 o_pN_rd_data SHALL hold its value until the next port-N read completes; writes SHALL NOT change it.
REQ-026 A request dropped during its ack cycle SHALL perform no write and no read capture.

Reset
REQ-027 While i_rst_n is low at posedge: state IDLE, last-served = 1 (port 0 wins first tie), burst count 0, o_pN_rd_data 0, o_pN_rd_valid 0.
REQ-028 Reset asserted mid-grant SHALL suppress that cycle's memory write and abort the transaction without ack completion.

Structure
REQ-029 State encodings (ARB_IDLE=2'd0, ARB_GNT0=2'd1, ARB_GNT1=2'd2) SHALL live in a shared package/header shared with the core control logic.
REQ-030 Next-owner selection (REQ-018) SHALL be a combinational sub-module arb_rr_pick; all registers SHALL stay in mem_arbiter.

Verification
REQ-031 Reset, then p0 write addr 0x005 data 0xBEEF; p1 read addr 0x005 next -> p1 rd_data 0xBEEF, rd_valid pulse 1 cycle after p1 ack.
REQ-032 Both request continuously, no lock -> acks alternate p0,p1,p0,p1 starting with p0.
REQ-033 p0 req+lock for 10 transactions, p1 requesting, p_MAX_BURST=4 -> p0 acked 4 cycles, then p1 for 1 cycle, then p0 again.
REQ-034 p0 req+lock, p1 idle -> p0 acked every cycle, no forced switch, burst count saturates at 3.
REQ-035 i_rst_n low in a GNT1 write cycle to 0x3FF -> o_mem_wr_en 0, memory at 0x3FF unchanged, state IDLE next cycle.
REQ-036 p0 drops req in its ack cycle with we=1 -> no write, no rd_valid, FSM returns to IDLE or grants p1.
